// File: rtl/c1541_sd_pkg.sv
// Shared types and widths for the C1541 SD-channel arbiter.
package c1541_sd_pkg;

   localparam int unsigned SD_LBA_W  = 32;
   localparam int unsigned SD_BUF_AW = 9;
   localparam int unsigned OWNER_W   = 2;

   typedef enum logic [1:0] {IDLE, REQ, XFER} arb_state_t;

endpackage

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin picker: first pending index after 'last', wrapping.
module c1541_rr_pick
   import c1541_sd_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] pend_i,
   input  logic [OWNER_W-1:0] last_i,
   output logic               valid_o,
   output logic [OWNER_W-1:0] idx_o
);

   logic [3:0]         pend4;
   logic [OWNER_W-1:0] cand;

   always_comb begin : pick
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      pend4   = 4'(pend_i);
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = OWNER_W'((32'(last_i) + k) % NUM_REQ);
         if (!valid_o && pend4[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one SD block channel between NUM_REQ track loaders.
// Optional watchdog enabled by defining C1541_SD_ARB_TIMEOUT_EN.
module c1541_sd_arbiter
   import c1541_sd_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned TIMEOUT_W = 24
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ*32-1:0]     req_lba,
   input  logic [NUM_REQ-1:0]        req_rd,
   input  logic [NUM_REQ-1:0]        req_wr,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [NUM_REQ-1:0]        req_buff_wr,
   input  logic [NUM_REQ*8-1:0]      req_buff_din,
   output logic [SD_LBA_W-1:0]       sd_lba,
   output logic                      sd_rd,
   output logic                      sd_wr,
   input  logic                      sd_ack,
   input  logic                      sd_buff_wr,
   output logic [7:0]                sd_buff_din,
   output logic [OWNER_W-1:0]        owner,
   output logic                      busy,
   output logic                      timeout
);

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_W < 2) begin : g_bad_param
      $error("c1541_sd_arbiter: unsupported NUM_REQ/TIMEOUT_W");
   end

   arb_state_t            state_q, state_d;
   logic [OWNER_W-1:0]    owner_q, owner_d;
   logic [OWNER_W-1:0]    last_q, last_d;
   logic [SD_LBA_W-1:0]   lba_q, lba_d;
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic                  busy_q, busy_d;
   logic                  old_ack_q, old_ack_d;

   logic [NUM_REQ-1:0]    pend;
   logic                  pick_valid;
   logic [OWNER_W-1:0]    pick_idx;
   logic [SD_LBA_W-1:0]   lba_sel;
   logic                  wr_sel;

   assign pend = req_rd | req_wr;

   c1541_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .pend_i  (pend),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Candidate address and direction of the requester the picker selected.
   always_comb begin : req_sel
      lba_sel = '0;
      wr_sel  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == OWNER_W'(i)) begin
            lba_sel = req_lba[SD_LBA_W*i +: SD_LBA_W];
            wr_sel  = req_wr[i];
         end
      end
   end

`ifdef C1541_SD_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic                  timeout_q, timeout_d;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin : state_reg
      if (!reset_n) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         last_q    <= OWNER_W'(NUM_REQ - 1);
         lba_q     <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         old_ack_q <= 1'b0;
`ifdef C1541_SD_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         lba_q     <= lba_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         busy_q    <= busy_d;
         old_ack_q <= old_ack_d;
`ifdef C1541_SD_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin : next_state
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      lba_d     = lba_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      busy_d    = busy_q;
      old_ack_d = sd_ack;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               lba_d   = lba_sel;
               wr_d    = wr_sel;
               rd_d    = !wr_sel;
               busy_d  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (sd_ack) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (old_ack_q && !sd_ack) begin
               busy_d  = 1'b0;
               last_d  = owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef C1541_SD_ARB_TIMEOUT_EN
      timeout_d = 1'b0;
      if (state_q == IDLE || state_d != state_q || sd_ack != old_ack_q) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + TIMEOUT_W'(1);
      end
      // Watchdog overrides any normal transition and abandons the transfer.
      if (state_q != IDLE && cnt_q == '1) begin
         rd_d      = 1'b0;
         wr_d      = 1'b0;
         busy_d    = 1'b0;
         last_d    = owner_q;
         state_d   = IDLE;
         cnt_d     = '0;
         timeout_d = 1'b1;
      end
`endif
   end

   // Only the current owner sees ack, buffer strobes and drives read-back data.
   always_comb begin : route
      req_ack     = '0;
      req_buff_wr = '0;
      sd_buff_din = '0;
      if (busy_q) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OWNER_W'(i)) begin
               req_ack[i]     = sd_ack;
               req_buff_wr[i] = sd_buff_wr;
               sd_buff_din    = req_buff_din[8*i +: 8];
            end
         end
      end
   end

   assign sd_lba = lba_q;
   assign sd_rd  = rd_q;
   assign sd_wr  = wr_q;
   assign owner  = owner_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Directed plus randomized bench for c1541_sd_arbiter with a round-robin reference model.
module tb_c1541_sd_arbiter;

   localparam int NR = 2;
   localparam int DW = NR * 8;
   localparam int NBUF = 1 << c1541_sd_pkg::SD_BUF_AW;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NR*32-1:0]  req_lba;
   logic [NR-1:0]     req_rd, req_wr, req_ack, req_buff_wr;
   logic [DW-1:0]     req_buff_din;
   logic [31:0]       sd_lba;
   logic              sd_rd, sd_wr, sd_ack, sd_buff_wr, busy, timeout;
   logic [7:0]        sd_buff_din;
   logic [1:0]        owner;

   int n_chk = 0;
   int n_pass = 0;

   c1541_sd_arbiter #(.NUM_REQ(NR), .TIMEOUT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
      .req_ack(req_ack), .req_buff_wr(req_buff_wr), .req_buff_din(req_buff_din),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
      .sd_buff_din(sd_buff_din), .owner(owner), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One complete sector transfer as seen by a well-behaved IO controller and requester.
   task automatic xfer(input int o, input bit w, input logic [31:0] lba, input int dly,
                       input int nbuf, input int pulse);
      int t;
      int hits;
      int bad;
      logic [NR-1:0] oh;
      t = 0;
      while (sd_rd !== 1'b1 && sd_wr !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      chk("grant_latency", 32'(t), 32'd1);
      chk("owner", 32'(owner), 32'(o));
      chk("dir_wr", 32'(sd_wr), 32'(w));
      chk("dir_rd", 32'(sd_rd), 32'(!w));
      chk("sd_lba", sd_lba, lba);
      chk("busy_grant", 32'(busy), 32'd1);
      repeat (dly) tick();
      chk("strobe_held", 32'(sd_rd | sd_wr), 32'd1);
      oh = '0;
      oh[o] = 1'b1;
      sd_ack = 1'b1;
      #1;
      chk("ack_route", 32'(req_ack), 32'(oh));
      req_rd[o] = 1'b0;
      req_wr[o] = 1'b0;
      tick();
      chk("strobe_clear", 32'({sd_rd, sd_wr}), 32'd0);
      chk("busy_xfer", 32'(busy), 32'd1);
      if (pulse >= 0) begin
         req_rd[pulse] = 1'b1;
         tick();
         req_rd[pulse] = 1'b0;
      end
      hits = 0;
      bad = 0;
      for (int k = 0; k < nbuf; k++) begin
         sd_buff_wr = 1'b1;
         #1;
         if (req_buff_wr === oh) hits++;
         else bad++;
         if (sd_buff_din !== req_buff_din[8*o +: 8]) bad++;
         sd_buff_wr = 1'b0;
         tick();
      end
      chk("buff_wr_hits", 32'(hits), 32'(nbuf));
      chk("buff_route_bad", 32'(bad), 32'd0);
      sd_ack = 1'b0;
      tick();
      chk("busy_done", 32'(busy), 32'd0);
      chk("owner_kept", 32'(owner), 32'(o));
      chk("ack_idle", 32'(req_ack), 32'd0);
      chk("din_idle", 32'(sd_buff_din), 32'd0);
   endtask

   bit          pm [NR];
   bit          wm [NR];
   logic [31:0] lm [NR];
   int          last_m;
   int          exp_o;
   int          d;
   int          c;
   int          t;
   bit          any;

   task automatic add_req(input int i);
      d = $urandom_range(1, 3);
      pm[i] = 1'b1;
      wm[i] = d[1];
      lm[i] = $urandom;
      req_rd[i] = d[0];
      req_wr[i] = d[1];
      req_lba[32*i +: 32] = lm[i];
   endtask

   initial begin
      reset_n = 1'b0;
      req_lba = '0;
      req_rd = '0;
      req_wr = '0;
      req_buff_din = '0;
      sd_ack = 1'b0;
      sd_buff_wr = 1'b0;
      repeat (3) tick();

      // Reset values
      chk("rst_sd_rd", 32'(sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(sd_wr), 32'd0);
      chk("rst_sd_lba", sd_lba, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      reset_n = 1'b1;
      tick();

      // Single read from requester 0
      req_rd[0] = 1'b1;
      req_lba[31:0] = 32'h0000_0115;
      xfer(0, 1'b0, 32'h0000_0115, 5, 4, -1);

      // Spurious ack while idle is not routed
      sd_ack = 1'b1;
      #1;
      chk("spurious_ack_route", 32'(req_ack), 32'd0);
      tick();
      chk("spurious_ack_busy", 32'(busy), 32'd0);
      sd_ack = 1'b0;
      tick();

      // Simultaneous requests from reset: rotation 0,1,0 then owner-1 read of a full sector
      reset_n = 1'b0;
      req_rd[0] = 1'b1;
      req_wr[1] = 1'b1;
      req_lba = {32'h0000_0300, 32'h0000_0200};
      req_buff_din = {8'h5A, 8'hA5};
      tick();
      reset_n = 1'b1;
      xfer(0, 1'b0, 32'h0000_0200, 2, 2, -1);
      xfer(1, 1'b1, 32'h0000_0300, 1, 4, -1);
      req_rd = 2'b11;
      req_lba = {32'h0000_0500, 32'h0000_0400};
      xfer(0, 1'b0, 32'h0000_0400, 0, 1, -1);
      xfer(1, 1'b0, 32'h0000_0500, 2, NBUF, -1);

      // Request withdrawn before it could be granted
      req_rd[0] = 1'b1;
      req_lba[31:0] = 32'h0000_0600;
      xfer(0, 1'b0, 32'h0000_0600, 2, 3, 1);
      repeat (5) tick();
      chk("withdrawn_no_rd", 32'(sd_rd), 32'd0);
      chk("withdrawn_no_busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of a transfer
      req_rd[0] = 1'b1;
      req_lba = {32'h0000_0777, 32'h0000_0700};
      tick();
      chk("midrst_grant", 32'(sd_rd), 32'd1);
      sd_ack = 1'b1;
      req_rd[0] = 1'b0;
      tick();
      req_rd[1] = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rd", 32'(sd_rd), 32'd0);
      chk("midrst_wr", 32'(sd_wr), 32'd0);
      chk("midrst_owner", 32'(owner), 32'd0);
      sd_ack = 1'b0;
      tick();
      reset_n = 1'b1;
      xfer(1, 1'b0, 32'h0000_0777, 1, 2, -1);

      // Randomized traffic against the round-robin reference model
      last_m = 1;
      for (int i = 0; i < NR; i++) pm[i] = 1'b0;
      for (int it = 0; it < 40; it++) begin
         any = 1'b0;
         for (int i = 0; i < NR; i++) begin
            if (!pm[i] && $urandom_range(0, 1) == 1) add_req(i);
            if (pm[i]) any = 1'b1;
         end
         if (!any) add_req(int'($urandom_range(0, NR - 1)));
         req_buff_din = DW'($urandom);
         exp_o = -1;
         for (int k = 1; k <= NR; k++) begin
            c = (last_m + k) % NR;
            if (exp_o < 0 && pm[c]) exp_o = c;
         end
         xfer(exp_o, wm[exp_o], lm[exp_o], int'($urandom_range(0, 4)),
              int'($urandom_range(0, 6)), -1);
         pm[exp_o] = 1'b0;
         last_m = exp_o;
      end
      req_rd = '0;
      req_wr = '0;

`ifdef C1541_SD_ARB_TIMEOUT_EN
      // Watchdog: grant with sd_ack never rising
      req_rd[0] = 1'b1;
      tick();
      chk("to_grant", 32'(sd_rd), 32'd1);
      t = 0;
      while (timeout !== 1'b1 && t < 40) begin
         tick();
         t++;
      end
      chk("to_window", 32'(t >= 15 && t <= 16), 32'd1);
      chk("to_rd", 32'(sd_rd), 32'd0);
      chk("to_busy", 32'(busy), 32'd0);
      req_rd[0] = 1'b0;
      tick();
      chk("to_pulse_width", 32'(timeout), 32'd0);
      chk("to_idle", 32'(busy), 32'd0);
`else
      repeat (3) tick();
      chk("timeout_tied", 32'(timeout), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
